// File: rtl/perf_mon_pkg.sv
// Shared types and helpers for the ap_ctrl handshake performance monitor.
// Provides the channel state enum, register map indices and saturating increment.
package perf_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_CONT = 2'd2
    } state_e;

    localparam int CHAN_W = 4;
    localparam int REG_W  = 3;
    localparam int MAX_W  = 48;

    localparam logic [REG_W-1:0] REG_NSTART = 3'd0;
    localparam logic [REG_W-1:0] REG_NDONE  = 3'd1;
    localparam logic [REG_W-1:0] REG_BUSY   = 3'd2;
    localparam logic [REG_W-1:0] REG_STALL  = 3'd3;
    localparam logic [REG_W-1:0] REG_ITERS  = 3'd4;
    localparam logic [REG_W-1:0] REG_STATUS = 3'd5;
    localparam logic [REG_W-1:0] REG_LATMIN = 3'd6;
    localparam logic [REG_W-1:0] REG_LATMAX = 3'd7;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [MAX_W-1:0] sat_inc(
        input logic [MAX_W-1:0] v,
        input int               w
    );
        logic [MAX_W-1:0] lim;
        lim = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return (v >= lim) ? v : v + MAX_W'(1);
    endfunction

endpackage

// File: rtl/perf_mon_channel.sv
// One monitored kernel: handshake FSM plus start/done/busy/stall/iter counters.
// Ports: clock/reset, clr_i (zero all), frz_i (hold this cycle), frozen_i (status bit),
//   ap_start_i/ap_done_i/ap_continue_i, iter_end_i/iter_block_i,
//   rd_reg_i -> rd_val_o (combinational register select), active_o, overflow_o.
// Macro PERF_MON_LATENCY_EN adds the lat_min/lat_max registers and their timer.
module perf_mon_channel
    import perf_mon_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             frz_i,
    input  logic             frozen_i,
    input  logic             ap_start_i,
    input  logic             ap_done_i,
    input  logic             ap_continue_i,
    input  logic             iter_end_i,
    input  logic             iter_block_i,
    input  logic [REG_W-1:0] rd_reg_i,
    output logic [CNT_W-1:0] rd_val_o,
    output logic             active_o,
    output logic             overflow_o
);

    localparam int NCNT = 5;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NCNT];
    logic [CNT_W-1:0] cnt_d [NCNT];
    logic             ovf_q, ovf_d;
    logic [NCNT-1:0]  inc;
    logic             start_e, done_e, lat_e;

    always_ff @(posedge clock) begin
        if (reset || clr_i) begin
            state_q <= IDLE;
        end else if (!frz_i) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ap_start_i) state_d = RUN;
            end
            RUN: begin
                if (ap_done_i) begin
                    if (!ap_continue_i) state_d = WAIT_CONT;
                    else                state_d = ap_start_i ? RUN : IDLE;
                end
            end
            WAIT_CONT: begin
                if (ap_continue_i) state_d = ap_start_i ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A start arriving while done waits on ap_continue is not accepted.
    always_comb begin
        start_e = 1'b0;
        done_e  = 1'b0;
        lat_e   = 1'b0;
        case (state_q)
            IDLE: start_e = ap_start_i;
            RUN: begin
                lat_e   = ap_done_i;
                done_e  = ap_done_i & ap_continue_i;
                start_e = done_e & ap_start_i;
            end
            WAIT_CONT: begin
                done_e  = ap_continue_i;
                start_e = ap_continue_i & ap_start_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        inc[REG_NSTART] = start_e;
        inc[REG_NDONE]  = done_e;
        inc[REG_BUSY]   = (state_q == RUN);
        inc[REG_STALL]  = (state_q == WAIT_CONT) ||
                          ((state_q == RUN) && iter_block_i);
        inc[REG_ITERS]  = (state_q != IDLE) && iter_end_i;
    end

    // Overflow flags an event lost because its counter was already full.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NCNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc[i]) begin
                cnt_d[i] = CNT_W'(sat_inc(MAX_W'(cnt_q[i]), CNT_W));
                if (cnt_q[i] == '1) ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clr_i) begin
            for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
            ovf_q <= 1'b0;
        end else if (!frz_i) begin
            for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
            ovf_q <= ovf_d;
        end
    end

`ifdef PERF_MON_LATENCY_EN
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] lmin_q, lmin_d;
    logic [CNT_W-1:0] lmax_q, lmax_d;
    logic [CNT_W-1:0] samp;

    // tmr counts RUN cycles before done; the done cycle adds one more.
    always_comb begin
        samp   = CNT_W'(sat_inc(MAX_W'(tmr_q), CNT_W));
        tmr_d  = tmr_q;
        lmin_d = lmin_q;
        lmax_d = lmax_q;
        if (start_e)               tmr_d = '0;
        else if (state_q == RUN)   tmr_d = samp;
        if (lat_e && samp < lmin_q) lmin_d = samp;
        if (lat_e && samp > lmax_q) lmax_d = samp;
    end

    always_ff @(posedge clock) begin
        if (reset || clr_i) begin
            tmr_q  <= '0;
            lmin_q <= '1;
            lmax_q <= '0;
        end else if (!frz_i) begin
            tmr_q  <= tmr_d;
            lmin_q <= lmin_d;
            lmax_q <= lmax_d;
        end
    end
`else
    logic unused_lat;
    assign unused_lat = lat_e;
`endif

    always_comb begin
        rd_val_o = '0;
        case (rd_reg_i)
            REG_NSTART: rd_val_o = cnt_q[0];
            REG_NDONE:  rd_val_o = cnt_q[1];
            REG_BUSY:   rd_val_o = cnt_q[2];
            REG_STALL:  rd_val_o = cnt_q[3];
            REG_ITERS:  rd_val_o = cnt_q[4];
            REG_STATUS: rd_val_o = CNT_W'({ovf_q, frozen_i, state_q});
`ifdef PERF_MON_LATENCY_EN
            REG_LATMIN: rd_val_o = lmin_q;
            REG_LATMAX: rd_val_o = lmax_q;
`endif
            default:    rd_val_o = '0;
        endcase
    end

    assign active_o   = (state_q != IDLE);
    assign overflow_o = ovf_q;

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel performance monitor for HLS ap_ctrl_hs/chain kernels.
// Ports: clock, reset (sync, high); per-channel ap_start/ap_done/ap_continue,
//   iter_end/iter_block; finish (freeze), clear (zero all); rd_en/rd_addr
//   {chan,reg} -> rd_data/rd_valid one cycle later; overflow, active per channel.
// Macro PERF_MON_LATENCY_EN enables per-channel lat_min/lat_max (regs 6, 7).
module ap_ctrl_perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         ap_start,
    input  logic [N_CH-1:0]         ap_done,
    input  logic [N_CH-1:0]         ap_continue,
    input  logic [N_CH-1:0]         iter_end,
    input  logic [N_CH-1:0]         iter_block,
    input  logic                    finish,
    input  logic                    clear,
    input  logic                    rd_en,
    input  logic [CHAN_W+REG_W-1:0] rd_addr,
    output logic [CNT_W-1:0]        rd_data,
    output logic                    rd_valid,
    output logic [N_CH-1:0]         overflow,
    output logic [N_CH-1:0]         active
);

    logic              frozen_q, frozen_d;
    logic              frz_eff;
    logic [CNT_W-1:0]  rd_data_q;
    logic              rd_valid_q;
    logic [CNT_W-1:0]  rd_sel;
    logic [CNT_W-1:0]  ch_rd [N_CH];
    logic [CHAN_W-1:0] rd_chan;
    logic [REG_W-1:0]  rd_reg;

    assign rd_chan  = rd_addr[CHAN_W+REG_W-1:REG_W];
    assign rd_reg   = rd_addr[REG_W-1:0];

    // The finish cycle's own events are already discarded.
    assign frozen_d = frozen_q | finish;
    assign frz_eff  = frozen_d;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            frozen_q <= 1'b0;
        end else begin
            frozen_q <= frozen_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        perf_mon_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .clr_i        (clear),
            .frz_i        (frz_eff),
            .frozen_i     (frozen_q),
            .ap_start_i   (ap_start[g]),
            .ap_done_i    (ap_done[g]),
            .ap_continue_i(ap_continue[g]),
            .iter_end_i   (iter_end[g]),
            .iter_block_i (iter_block[g]),
            .rd_reg_i     (rd_reg),
            .rd_val_o     (ch_rd[g]),
            .active_o     (active[g]),
            .overflow_o   (overflow[g])
        );
    end

    // Channels beyond N_CH fall through to zero.
    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_chan == CHAN_W'(c)) rd_sel = ch_rd[c];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_sel;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Self-checking bench for ap_ctrl_perf_monitor (N_CH=4, CNT_W=8).
// Directed scenarios plus randomized traffic against a transaction-level model.
module tb_ap_ctrl_perf_monitor;

    localparam int     NC   = 4;
    localparam int     CW   = 8;
    localparam longint MAXC = (64'd1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [NC-1:0] ap_start, ap_done, ap_continue, iter_end, iter_block;
    logic          finish, clear, rd_en;
    logic [6:0]    rd_addr;
    logic [CW-1:0] rd_data;
    logic          rd_valid;
    logic [NC-1:0] overflow, active;

    always #5 clock = ~clock;

    ap_ctrl_perf_monitor #(
        .N_CH (NC),
        .CNT_W(CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_continue(ap_continue),
        .iter_end   (iter_end),
        .iter_block (iter_block),
        .finish     (finish),
        .clear      (clear),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .overflow   (overflow),
        .active     (active)
    );

    // Model: phase 0 idle, 1 running, 2 done-awaiting-continue.
    int     ph [NC];
    longint ns [NC], nd [NC], bz [NC], st [NC], it [NC];
    longint lmin [NC], lmax [NC], ts [NC];
    bit     ov [NC];
    bit     frz;
    longint cyc = 0;

    logic [CW-1:0] exp_data;
    logic          exp_valid;
    int            n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic longint bump(input longint v, input int c);
        if (v >= MAXC) begin
            ov[c] = 1'b1;
            return v;
        end
        return v + 1;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            ph[c] = 0; ns[c] = 0; nd[c] = 0; bz[c] = 0; st[c] = 0;
            it[c] = 0; ov[c] = 0; lmin[c] = MAXC; lmax[c] = 0; ts[c] = 0;
        end
        frz = 1'b0;
    endtask

    task automatic end_txn(input int c, input bit s);
        nd[c] = bump(nd[c], c);
        if (s) begin
            ns[c] = bump(ns[c], c);
            ph[c] = 1;
            ts[c] = cyc;
        end else begin
            ph[c] = 0;
        end
    endtask

    task automatic chan_step(input int c);
        longint lat;
        bit s, d, k;
        s = ap_start[c]; d = ap_done[c]; k = ap_continue[c];
        if (ph[c] == 1) bz[c] = bump(bz[c], c);
        if (ph[c] == 2 || (ph[c] == 1 && iter_block[c]))
            st[c] = bump(st[c], c);
        if (ph[c] != 0 && iter_end[c]) it[c] = bump(it[c], c);
        case (ph[c])
            0: if (s) begin
                ns[c] = bump(ns[c], c);
                ph[c] = 1;
                ts[c] = cyc;
            end
            1: if (d) begin
                lat = cyc - ts[c];
                if (lat > MAXC) lat = MAXC;
                if (lat < lmin[c]) lmin[c] = lat;
                if (lat > lmax[c]) lmax[c] = lat;
                if (k) end_txn(c, s);
                else   ph[c] = 2;
            end
            default: if (k) end_txn(c, s);
        endcase
    endtask

    function automatic logic [CW-1:0] model_read(input logic [6:0] a);
        int c, r;
        logic [1:0] p;
        c = int'(a[6:3]);
        r = int'(a[2:0]);
        if (c >= NC) return '0;
        p = ph[c][1:0];
        case (r)
            0: return CW'(ns[c]);
            1: return CW'(nd[c]);
            2: return CW'(bz[c]);
            3: return CW'(st[c]);
            4: return CW'(it[c]);
            5: return CW'({ov[c], frz, p});
`ifdef PERF_MON_LATENCY_EN
            6: return CW'(lmin[c]);
            7: return CW'(lmax[c]);
`endif
            default: return '0;
        endcase
    endfunction

    function automatic logic [NC-1:0] model_active();
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = (ph[c] != 0);
        return v;
    endfunction

    function automatic logic [NC-1:0] model_ovf();
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = ov[c];
        return v;
    endfunction

    // One clock: advance the model on the applied inputs, then compare.
    task automatic tick();
        if (reset) begin
            model_clear();
            exp_data  = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = rd_en;
            if (rd_en) exp_data = model_read(rd_addr);
            if (clear) model_clear();
            else begin
                if (!(frz || finish))
                    for (int c = 0; c < NC; c++) chan_step(c);
                if (finish) frz = 1'b1;
            end
        end
        cyc++;
        @(posedge clock);
        #1;
        chk("rd_valid", rd_valid, exp_valid);
        chk("rd_data", rd_data, exp_data);
        chk("active", active, model_active());
        chk("overflow", overflow, model_ovf());
    endtask

    task automatic rd_const(input logic [6:0] a, input string tag,
                            input logic [31:0] expv);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        chk(tag, rd_data, expv);
        rd_en   = 1'b0;
    endtask

    task automatic idle_inputs();
        ap_start = '0; ap_done = '0; ap_continue = '1;
        iter_end = '0; iter_block = '0;
        finish = 1'b0; clear = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rd_addr = '0;
        reset   = 1'b1;
        repeat (3) tick();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_active", active, 0);
        reset = 1'b0;
        tick();

        for (int r = 0; r < 6; r++)
            rd_const(7'(r), "rst_ch0_reg", 0);
`ifdef PERF_MON_LATENCY_EN
        rd_const(7'd6, "rst_latmin", MAXC);
        rd_const(7'd7, "rst_latmax", 0);
`endif
        tick();

        // ch1: start, 8 running cycles with 7 iterations, done 9 after start
        ap_start[1] = 1'b1; tick(); ap_start[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iter_end[1] = (i < 7);
            tick();
        end
        iter_end[1] = 1'b0;
        ap_done[1] = 1'b1; tick(); ap_done[1] = 1'b0;
        tick();
        rd_const({4'd1, 3'd0}, "ch1_nstart", 1);
        rd_const({4'd1, 3'd1}, "ch1_ndone", 1);
        rd_const({4'd1, 3'd2}, "ch1_busy", 9);
        rd_const({4'd1, 3'd4}, "ch1_iters", 7);
`ifdef PERF_MON_LATENCY_EN
        rd_const({4'd1, 3'd6}, "ch1_latmin", 9);
        rd_const({4'd1, 3'd7}, "ch1_latmax", 9);
`endif

        // ch0: three back-to-back 5-cycle transactions
        ap_start[0] = 1'b1; tick();
        for (int t = 0; t < 3; t++) begin
            ap_start[0] = 1'b0;
            repeat (4) begin
                tick();
                chk("b2b_active", active[0], 1);
            end
            ap_done[0]  = 1'b1;
            ap_start[0] = (t < 2);
            tick();
            chk("b2b_active_done", active[0], (t < 2));
            ap_done[0] = 1'b0;
        end
        ap_start[0] = 1'b0;
        rd_const({4'd0, 3'd0}, "b2b_nstart", 3);
        rd_const({4'd0, 3'd1}, "b2b_ndone", 3);
        rd_const({4'd0, 3'd2}, "b2b_busy", 15);

        // ch2: done held off by ap_continue for four cycles
        ap_start[2] = 1'b1; tick(); ap_start[2] = 1'b0;
        repeat (3) tick();
        ap_done[2] = 1'b1; ap_continue[2] = 1'b0; tick();
        ap_done[2] = 1'b0;
        rd_const({4'd2, 3'd5}, "ch2_wait_state", 2);
        rd_const({4'd2, 3'd1}, "ch2_ndone_wait", 0);
        tick();
        ap_continue[2] = 1'b1; tick();
        rd_const({4'd2, 3'd3}, "ch2_stall", 4);
        rd_const({4'd2, 3'd1}, "ch2_ndone", 1);

        // ch3: 300 iterations saturate an 8-bit counter
        ap_start[3] = 1'b1; tick(); ap_start[3] = 1'b0;
        iter_end[3] = 1'b1;
        repeat (300) tick();
        iter_end[3] = 1'b0;
        rd_const({4'd3, 3'd4}, "ch3_iters_sat", 255);
        chk("ch3_ovf", overflow[3], 1);
        ap_done[3] = 1'b1; tick(); ap_done[3] = 1'b0;
        repeat (5) tick();
        chk("ch3_ovf_sticky", overflow[3], 1);
        clear = 1'b1; tick(); clear = 1'b0;
        rd_const({4'd3, 3'd4}, "ch3_iters_clr", 0);
        chk("ovf_clr", overflow, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NC; c++) begin
                ap_start[c]    = ($urandom_range(0, 3) == 0);
                ap_done[c]     = ($urandom_range(0, 5) == 0);
                ap_continue[c] = ($urandom_range(0, 3) != 0);
                iter_end[c]    = ($urandom_range(0, 1) == 0);
                iter_block[c]  = ($urandom_range(0, 4) == 0);
            end
            clear   = ($urandom_range(0, 199) == 0);
            finish  = ($urandom_range(0, 399) == 0);
            rd_en   = ($urandom_range(0, 1) == 0);
            rd_addr = {4'($urandom_range(0, 5)), 3'($urandom_range(0, 7))};
            tick();
        end
        idle_inputs();
        clear = 1'b1; tick(); clear = 1'b0;

        // freeze mid-transaction, then more activity
        ap_start[0] = 1'b1; tick(); ap_start[0] = 1'b0;
        iter_end[0] = 1'b1;
        repeat (3) tick();
        finish = 1'b1; tick(); finish = 1'b0;
        iter_end[0] = 1'b0;
        ap_done[0] = 1'b1; ap_start[1] = 1'b1; tick();
        ap_done[0] = 1'b0; ap_start[1] = 1'b0;
        repeat (4) tick();
        rd_const({4'd0, 3'd0}, "frz_nstart", 1);
        rd_const({4'd0, 3'd1}, "frz_ndone", 0);
        rd_const({4'd0, 3'd4}, "frz_iters", 3);
        rd_const({4'd1, 3'd0}, "frz_ch1_nstart", 0);
        rd_const({4'd0, 3'd5}, "frz_status", 5);
        rd_const({4'd9, 3'd0}, "bad_chan", 0);

        // clear wins over same-cycle events
        clear = 1'b1; ap_start = '1; iter_end = '1; tick();
        idle_inputs();
        for (int c = 0; c < NC; c++)
            rd_const({4'(c), 3'd0}, "clr_nstart", 0);
        rd_const({4'd0, 3'd5}, "clr_status", 0);
        chk("clr_active", active, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
